debug_uart_tx: RTL and testbench

Byte sink for the debugger response path: buffers bytes written by the debug state machine (`wr`/`w_data`, up to four bytes per result word, most significant first) in a small FIFO and serialises them as 8N1 UART frames on `tx`. Sits directly downstream of the debug sequencer and drives the board's serial output pin.

---
 rtl/debug_uart_tx.sv | 202 ++++++++++++++++++++
 tb/tb_debug_uart_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/debug_uart_tx.sv
// debug_uart_tx
//   Byte sink for the debugger response path. Bytes written by the debug
//   sequencer are held in a small circular FIFO and sent out as 8N1 UART
//   frames, LSB first, with no idle gap between queued frames.
//
// Parameters
//   CLK_DIV  clock cycles per UART bit (>= 2)
//   ADDR_W   FIFO address width, depth = 2**ADDR_W bytes
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   wr        write strobe, one byte per cycle while high
//   w_data    byte to enqueue when wr is high
//   tx        UART serial line, idle high (registered)
//   tx_full   FIFO holds 2**ADDR_W entries (registered)
//   tx_empty  FIFO holds no entries (registered)
//   busy      transmitter is sending a frame (registered)
//   overflow  sticky: a write was dropped because the FIFO was full
module debug_uart_tx #(
    parameter int unsigned CLK_DIV = 434,
    parameter int unsigned ADDR_W  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic [7:0] w_data,
    output logic       tx,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CW    = ADDR_W + 1;
    localparam int unsigned TW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_n;
    logic              push;
    logic              pop;

    // Transmitter
    state_t            state;
    state_t            state_n;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_n;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_n;
    logic [7:0]        shift;
    logic [7:0]        shift_n;
    logic              tx_n;
    logic              bit_last;

    // Writes are gated by the registered full flag, so a pop in the same
    // cycle does not rescue a write into a full FIFO.
    assign push = wr & ~tx_full;

    always_comb begin
        count_n = count;
        unique case ({push, pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx_full  <= 1'b0;
            tx_empty <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_n;
            tx_full  <= (count_n == CW'(DEPTH));
            tx_empty <= (count_n == '0);
            if (wr && tx_full) begin
                overflow <= 1'b1;
            end
        end
    end

    assign bit_last = (timer == TW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, datapath and pop decode. tx and busy are registered from
    // the next state so they change in the same cycle the state does.
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;

        unique case (state)
            IDLE: begin
                timer_n = '0;
                if (!tx_empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    state_n = START;
                end
            end
            START: begin
                if (bit_last) begin
                    timer_n   = '0;
                    bit_idx_n = '0;
                    state_n   = DATA;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            DATA: begin
                if (bit_last) begin
                    timer_n = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            STOP: begin
                if (bit_last) begin
                    timer_n = '0;
                    if (!tx_empty) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            timer   <= timer_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
            busy    <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_debug_uart_tx.sv
// tb_debug_uart_tx
//   Directed bench for debug_uart_tx with CLK_DIV=4, ADDR_W=2.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_debug_uart_tx;

    localparam int unsigned DIV = 4;

    logic       clk;
    logic       reset;
    logic       wr;
    logic [7:0] w_data;
    logic       tx;
    logic       tx_full;
    logic       tx_empty;
    logic       busy;
    logic       overflow;

    int checks;
    int errors;

    debug_uart_tx #(
        .CLK_DIV (DIV),
        .ADDR_W  (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .w_data   (w_data),
        .tx       (tx),
        .tx_full  (tx_full),
        .tx_empty (tx_empty),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Checks one frame of byte b cycle by cycle, starting at cycle offset
    // skip into the frame. Returns at the first cycle after the stop bit.
    task automatic check_frame(input logic [7:0] b, input int unsigned skip);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int unsigned k = skip; k < 10 * DIV; k++) begin
            chk($sformatf("frame_%02h_slot%0d_tx", b, k / DIV), tx, fr[k / DIV]);
            chk($sformatf("frame_%02h_slot%0d_busy", b, k / DIV), busy, 1'b1);
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        wr     = 1'b0;
        w_data = 8'h00;

        // Reset behaviour
        tick();
        tick();
        chk("rst_hold_tx", tx, 1'b1);
        chk("rst_hold_empty", tx_empty, 1'b1);
        reset = 1'b1;
        tick();
        chk("rst_tx", tx, 1'b1);
        chk("rst_empty", tx_empty, 1'b1);
        chk("rst_full", tx_full, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        for (int i = 0; i < 100; i++) begin
            chk("idle_tx", tx, 1'b1);
            chk("idle_busy", busy, 1'b0);
            tick();
        end

        // Single frame 0xA5: write in cycle 0, start bit in cycle 2
        wr = 1'b1;
        w_data = 8'hA5;
        tick();
        wr = 1'b0;
        chk("single_c1_empty", tx_empty, 1'b0);
        chk("single_c1_tx", tx, 1'b1);
        chk("single_c1_busy", busy, 1'b0);
        tick();
        chk("single_c2_empty", tx_empty, 1'b1);
        check_frame(8'hA5, 0);
        chk("single_end_busy", busy, 1'b0);
        chk("single_end_tx", tx, 1'b1);
        chk("single_end_empty", tx_empty, 1'b1);

        // Four-byte burst: frames back to back, FIFO never full
        wr = 1'b1;
        w_data = 8'h12;
        tick();
        chk("burst_c1_full", tx_full, 1'b0);
        w_data = 8'h34;
        tick();
        chk("burst_c2_full", tx_full, 1'b0);
        w_data = 8'h56;
        tick();
        chk("burst_c3_full", tx_full, 1'b0);
        w_data = 8'h78;
        tick();
        wr = 1'b0;
        chk("burst_c4_full", tx_full, 1'b0);
        check_frame(8'h12, 2);
        check_frame(8'h34, 0);
        check_frame(8'h56, 0);
        check_frame(8'h78, 0);
        chk("burst_end_busy", busy, 1'b0);
        chk("burst_end_overflow", overflow, 1'b0);
        chk("burst_end_empty", tx_empty, 1'b1);

        // Overflow: sixth byte in consecutive cycles is dropped
        for (int i = 0; i < 6; i++) begin
            wr = 1'b1;
            w_data = 8'(i + 1);
            if (i == 5) begin
                chk("ovf_c5_full", tx_full, 1'b1);
                chk("ovf_c5_overflow", overflow, 1'b0);
            end
            tick();
        end
        wr = 1'b0;
        chk("ovf_c6_overflow", overflow, 1'b1);
        check_frame(8'h01, 4);
        check_frame(8'h02, 0);
        check_frame(8'h03, 0);
        check_frame(8'h04, 0);
        check_frame(8'h05, 0);
        chk("ovf_end_busy", busy, 1'b0);
        chk("ovf_end_empty", tx_empty, 1'b1);
        for (int i = 0; i < 12; i++) begin
            chk("ovf_after_tx", tx, 1'b1);
            chk("ovf_after_sticky", overflow, 1'b1);
            tick();
        end

        // Pointer wrap-around with single-byte transactions
        for (int i = 0; i < 10; i++) begin
            wr = 1'b1;
            w_data = 8'(i);
            tick();
            wr = 1'b0;
            tick();
            check_frame(8'(i), 0);
            chk("wrap_end_busy", busy, 1'b0);
        end

        // Reset during DATA bit 3 of 0xFF with two bytes still queued
        wr = 1'b1;
        w_data = 8'hFF;
        tick();
        w_data = 8'hAA;
        tick();
        w_data = 8'h55;
        tick();
        wr = 1'b0;
        // now cycle 3; DATA bit 3 spans cycles 18..21
        for (int i = 3; i < 19; i++) begin
            tick();
        end
        chk("midrst_pre_busy", busy, 1'b1);
        chk("midrst_pre_empty", tx_empty, 1'b0);
        chk("midrst_pre_tx", tx, 1'b1);
        reset = 1'b0;
        #1;
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_empty", tx_empty, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            chk("midrst_after_tx", tx, 1'b1);
            chk("midrst_after_busy", busy, 1'b0);
            chk("midrst_after_empty", tx_empty, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
